// File: rtl/booth_r4_mul.sv
// booth_r4_mul: iterative radix-4 Booth multiplier with valid/ready handshakes.
// - Each operand is independently signed or unsigned.
// - Both operands are extended to N+2 bits, so all four mode combinations become
//   one signed multiply.
// - Two multiplier bits are retired per cycle over N/2+1 steps.
// - Optional feature: define BOOTH_R4_ZERO_BYPASS_EN to make zero operands skip
//   the iteration and complete one edge after accept.
// - N must be even and >= 4.
module booth_r4_mul #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N/2+2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             a_signed,
    input  logic             b_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy
);

    // Accumulator width leaves headroom for +/-2A of an (N+2)-bit multiplicand.
    localparam int AW = N + 4;
    // Multiplier width after extension; even, so the top triplet carries the sign.
    localparam int BW = N + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N/2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]      cnt_q;
    logic signed [AW-1:0]  mcand_q;
    logic signed [AW-1:0]  hi_q;
    logic [BW-1:0]         lo_q;
    logic                  bm1_q;

    logic                  accept;
    logic                  zero_op;
    logic                  last_step;
    logic signed [AW-1:0]  pp;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  hi_nxt;
    logic [BW-1:0]         lo_nxt;
    logic                  bm1_nxt;
    logic [2*N-1:0]        acc_done;

    // Extend the multiplicand to accumulator width according to its mode.
    function automatic logic signed [AW-1:0] ext_mcand(input logic [N-1:0] v,
                                                       input logic sgn);
        ext_mcand = {{4{sgn & v[N-1]}}, v};
    endfunction

    // Extend the multiplier to N+2 bits; unsigned operands get a 0 sign bit.
    function automatic logic [BW-1:0] ext_mplier(input logic [N-1:0] v,
                                                 input logic sgn);
        ext_mplier = {{2{sgn & v[N-1]}}, v};
    endfunction

    // Radix-4 Booth recoding of one triplet {b[i+1], b[i], b[i-1]}.
    function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                      input logic signed [AW-1:0] m);
        case (trip)
            3'b001, 3'b010: booth_pp = m;
            3'b011:         booth_pp = m <<< 1;
            3'b100:         booth_pp = -(m <<< 1);
            3'b101, 3'b110: booth_pp = -m;
            default:        booth_pp = '0;
        endcase
    endfunction

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_step = (cnt_q == LAST_CNT);

`ifdef BOOTH_R4_ZERO_BYPASS_EN
    // A zero operand makes the product trivially zero; no iteration needed.
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // One Booth step: add the recoded partial product, then shift the pair right by 2.
    always_comb begin
        pp      = booth_pp({lo_q[1:0], bm1_q}, mcand_q);
        sum     = hi_q + pp;
        hi_nxt  = sum >>> 2;
        lo_nxt  = {sum[1:0], lo_q[BW-1:2]};
        bm1_nxt = lo_q[1];
        // Low 2N bits of the (2N+6)-bit result after the final shift.
        acc_done = (2*N)'({hi_nxt, lo_nxt});
    end

    // State register; reset returns to IDLE and drops any partial result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the handshake outputs decoded from the state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Step counter: cleared on accept, advances once per RUN step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Product register: loaded on the final step, held through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            product <= '0;
        end else if (accept && zero_op) begin
            product <= '0;
        end else if ((state_q == RUN) && last_step) begin
            product <= acc_done;
        end
    end

    // Operand capture and accumulator update; the FSM decides when it matters.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand_q <= ext_mcand(a, a_signed);
            hi_q    <= '0;
            lo_q    <= ext_mplier(b, b_signed);
            bm1_q   <= 1'b0;
        end else if (state_q == RUN) begin
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            bm1_q   <= bm1_nxt;
        end
    end

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul (N=32): directed vectors, expected products queued at issue
// and compared by an independent monitor when the DUT hands over a result.
module tb_booth_r4_mul;

    localparam int N = 32;
`ifdef BOOTH_R4_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = N/2 + 1;
`endif
    localparam int LAT = N/2 + 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic            a_signed;
    logic            b_signed;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  product;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*N-1:0] exp_q[$];

    booth_r4_mul #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // Monitor: every accepted output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("sb_product", product, exp_q.pop_front());
        end
    end

    // Issue one operation from an IDLE cycle (entered at posedge+1) through its handshake.
    task automatic do_op(input string nm, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tas, input logic tbs, input logic [2*N-1:0] exp,
                         input int exp_lat, input bit bp);
        int lat;
        check({nm, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a = ta; b = tb; a_signed = tas; b_signed = tbs;
        in_valid = 1'b1;
        if (bp) out_ready = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (bp) begin
                check({nm, "_in_ready_run"}, 64'(in_ready), 64'd0);
                in_valid = lat[0];
                a = $urandom; b = $urandom;
                a_signed = ~a_signed; b_signed = ~b_signed;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        if (bp) begin
            for (int i = 0; i < 10; i++) begin
                check({nm, "_bp_product"}, product, exp);
                check({nm, "_bp_in_ready"}, 64'(in_ready), 64'd0);
                check({nm, "_bp_out_valid"}, 64'(out_valid), 64'd1);
                in_valid = ~in_valid;
                a = $urandom; b = $urandom;
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({nm, "_out_valid_after"}, 64'(out_valid), 64'd0);
        check({nm, "_in_ready_after"}, 64'(in_ready), 64'd1);
        check({nm, "_product_held"}, product, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", product, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op("ss_m3_m4",  32'hFFFF_FFFD, 32'hFFFF_FFFC, 1, 1, 64'd12, LAT, 0);
        do_op("ss_m345_97", -32'sd345, 32'd97, 1, 1, 64'hFFFF_FFFF_FFFF_7D47, LAT, 0);
        do_op("uu_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 64'hFFFF_FFFE_0000_0001, LAT, 0);
        do_op("su_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 64'hFFFF_FFFF_0000_0001, LAT, 0);
        do_op("ss_minmin", 32'h8000_0000, 32'h8000_0000, 1, 1, 64'h4000_0000_0000_0000, LAT, 0);
        do_op("ss_min_3",  32'h8000_0000, 32'd3, 1, 1, 64'hFFFF_FFFE_8000_0000, LAT, 0);
        do_op("ss_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1, 1, 64'hC000_0000_8000_0000, LAT, 0);
        do_op("us_min_m2", 32'h8000_0000, 32'hFFFF_FFFE, 0, 1, 64'hFFFF_FFFF_0000_0000, LAT, 0);
        do_op("uu_big",    32'd123456789, 32'd1000, 0, 0, 64'h0000_001C_BE99_1A08, LAT, 0);
        do_op("zero_a",    32'd0, 32'hFFFF_FFFB, 1, 1, 64'd0, ZLAT, 0);
        do_op("bp_1000_m7", 32'd1000, 32'hFFFF_FFF9, 1, 1, 64'hFFFF_FFFF_FFFF_E4A8, LAT, 1);
        do_op("after_bp",  32'd5, 32'd5, 0, 0, 64'd25, LAT, 0);

        // Reset in the middle of RUN: the partial result must never surface.
        a = 32'h1234_5678; b = 32'd3; a_signed = 1'b0; b_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_product", product, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        do_op("post_rst_7x6", 32'd7, 32'd6, 1, 1, 64'd42, LAT, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_r4_mul.md
Name: booth_r4_mul

Overview:
- Parametrised, iterative radix-4 Booth multiplier; successor to the radix-2 Booth2 block.
- Adds independent signed/unsigned operand modes (covers MUL, MULH, MULHSU and MULHU for the RV32IM M-extension unit).
- Adds valid/ready handshakes on input and output.
- Retires two multiplier bits per cycle; returns the full 2N-bit product.

Parameters:
- N, 32, operand width; must be even and >= 4.
- CNT_W, $clog2(N/2+2), iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low (rst=0 resets on the clk edge).
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- a_signed  in  1  1: a is two's complement; 0: a is unsigned.
- b_signed  in  1  1: b is two's complement; 0: b is unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2N  signed 2N-bit product of the extended operands.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0.
  - Reset dominates every other input, including mid-RUN; a partial result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture operands and go to RUN with counter=0.
  - Capture extends a and b to N+2 bits: sign-extend if the *_signed bit is 1, else zero-extend.
  - Capture clears the accumulator and sets the Booth appended bit b[-1]=0.
- RUN:
  - in_ready=0; one radix-4 step per edge.
  - Each step examines the multiplier triplet {b[i+1], b[i], b[i-1]} and adds to the upper accumulator: 0, +A, +2A, -A or -2A.
  - The adder is N+4 bits wide so that ±2A cannot overflow.
  - After the add, the accumulator arithmetic-shifts right by 2.
  - Exactly N/2+1 steps (17 for N=32); after the last step go to DONE.
- DONE:
  - out_valid=1, product holds the low 2N bits of the result, stable until accepted.
  - On an edge with out_ready=1, go to IDLE and set out_valid=0.
  - out_ready=0 holds the result indefinitely.
  - in_ready stays 0 in DONE; no accept in the same edge as output handshake. New operands are accepted in IDLE only, one cycle after.
- Latency: out_valid rises N/2+1 edges after the accepting edge. Throughput is one product per N/2+3 cycles with out_ready held 1.
- in_valid asserted while busy is ignored; operands are sampled only on the accepting edge. Changes to a/b during RUN have no effect.
- Arithmetic:
  - The result equals ext(a) × ext(b) exactly for all four mode combinations.
  - product is that value truncated to 2N bits; no overflow is possible at 2N.
- Corner cases all produce exact results:
  - a = most-negative signed value;
  - b = most-negative signed value;
  - 0 × anything;
  - all-ones unsigned × all-ones unsigned.
- product retains its last value in IDLE (not cleared) and is cleared only by reset.

Optional Feature:
- Macro: BOOTH_R4_ZERO_BYPASS_EN.
- When defined:
  - If a==0 or b==0 on the accepting edge, skip RUN and go directly to DONE.
  - product=0 and out_valid=1 one edge after accept.
  - Non-zero operands behave as in the base design.
- When undefined: every operation takes the full N/2+1 steps, zero operands included.

Test Plan:
- N=32, signed/signed, a=-3, b=-4 -> product=12; out_valid exactly 17 edges after accept.
- Signed/signed, a=-345, b=97 -> product=-33465 (0xFFFFFFFFFFFF7D47).
- Unsigned/unsigned, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. Signed/unsigned (MULHSU), a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFF00000001. Signed/signed, a=b=0x80000000 -> product=0x4000000000000000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid; toggle in_valid, a and b during RUN and DONE.
  - Required: product stable and in_ready=0 throughout; the single handshake returns to IDLE; the next accepted op is correct.
- Reset mid-operation:
  - Stimulus: drive rst=0 at step 8 of RUN.
  - Required: next edge gives IDLE, out_valid=0, product=0, in_ready=1; the following op 7×6 -> 42.
- With BOOTH_R4_ZERO_BYPASS_EN: a=0, b=-5 -> product=0, out_valid one edge after accept. Without the macro: the same stimulus gives out_valid 17 edges after accept.
